// File: rtl/fp16_pkg.sv
// Shared binary16 types, constants and operand classification for the PE
// multiply/accumulate datapath.
package fp16_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] mant;
    } fp16_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp16_class_e;

    localparam int unsigned FP16_BIAS = 15;
    localparam logic [15:0] FP16_QNAN = 16'h7D00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;

    // Subnormals collapse into ZERO so the datapath never sees them.
    function automatic fp16_class_e fp16_class(input fp16_t x);
        fp16_class_e c;
        if (x.exp == 5'd0) begin
            c = ZERO;
        end else if (x.exp == 5'h1F) begin
            c = (x.mant == 10'd0) ? INF : NAN;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/mul_fp16_pipe_if.sv
// Operand/result bundle between the PE sequencer and the fp16 multiplier.
interface mul_fp16_pipe_if;
    logic        start;
    logic        stall;
    logic [15:0] fp1_in;
    logic [15:0] fp2_in;
    logic [15:0] fp_out;
    logic        valid_out;

    modport master (output start, stall, fp1_in, fp2_in, input fp_out, valid_out);
    modport slave  (input start, stall, fp1_in, fp2_in, output fp_out, valid_out);
endinterface

// File: rtl/fp16_round_pack.sv
// Normalize a 22-bit significand product, round to nearest even, apply the
// overflow/flush-to-zero range check and pack a binary16 result.
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic              sign,
    input  logic signed [6:0] biased_exp,
    input  logic [21:0]       prod,
    output logic [15:0]       result
);

    logic [9:0]        mant_s;
    logic              guard_s;
    logic              sticky_s;
    logic              round_up_s;
    logic [10:0]       rounded_s;
    logic signed [6:0] norm_exp_s;
    logic signed [6:0] final_exp_s;
    logic [9:0]        final_mant_s;

    // Normalize, RNE round and range-check; exponent is checked after rounding.
    always_comb begin
        if (prod[21]) begin
            mant_s     = prod[20:11];
            guard_s    = prod[10];
            sticky_s   = |prod[9:0];
            norm_exp_s = biased_exp + 7'sd1;
        end else begin
            mant_s     = prod[19:10];
            guard_s    = prod[9];
            sticky_s   = |prod[8:0];
            norm_exp_s = biased_exp;
        end

        round_up_s = guard_s & (sticky_s | mant_s[0]);
        rounded_s  = {1'b0, mant_s} + {10'd0, round_up_s};

        if (rounded_s[10]) begin
            final_exp_s  = norm_exp_s + 7'sd1;
            final_mant_s = 10'd0;
        end else begin
            final_exp_s  = norm_exp_s;
            final_mant_s = rounded_s[9:0];
        end

        if (final_exp_s >= 7'sd31) begin
            result = {sign, 5'h1F, 10'h000};
        end else if (final_exp_s <= 7'sd0) begin
            result = {sign, 15'h0000};
        end else begin
            result = {sign, final_exp_s[4:0], final_mant_s};
        end
    end

endmodule

// File: rtl/mul_fp16_pipe.sv
// Pipelined binary16 multiplier for the systolic PE: DAZ/FTZ, canonical NaN,
// RNE. Operands captured at edge N are presented on fp_out after edge N+3.
module mul_fp16_pipe #(
    parameter int unsigned LAT = 3
) (
    input  logic             clk,
    input  logic             RST,
    mul_fp16_pipe_if.slave   bus
);
    import fp16_pkg::*;

    logic              op_valid_r;
    fp16_t             op_a_r;
    fp16_t             op_b_r;

    fp16_class_e       cls_a_s;
    fp16_class_e       cls_b_s;
    logic              sign_s;
    logic signed [6:0] exp_sum_s;
    logic              special_s;
    logic [15:0]       special_val_s;

    logic              s1_valid_r;
    logic              s1_sign_r;
    logic signed [6:0] s1_exp_r;
    logic [10:0]       s1_sig_a_r;
    logic [10:0]       s1_sig_b_r;
    logic              s1_special_r;
    logic [15:0]       s1_special_val_r;

    logic              s2_valid_r;
    logic              s2_sign_r;
    logic signed [6:0] s2_exp_r;
    logic [21:0]       s2_prod_r;
    logic              s2_special_r;
    logic [15:0]       s2_special_val_r;

    logic [15:0]       packed_s;
    logic [15:0]       fp_out_r;
    logic              valid_out_r;

    // Operand capture; a start during stall is dropped.
    always_ff @(posedge clk) begin
        if (RST) begin
            op_valid_r <= 1'b0;
            op_a_r     <= '0;
            op_b_r     <= '0;
        end else if (!bus.stall) begin
            op_valid_r <= bus.start;
            op_a_r     <= bus.fp1_in;
            op_b_r     <= bus.fp2_in;
        end
    end

    // Classify operands and resolve special results by precedence.
    always_comb begin
        cls_a_s   = fp16_class(op_a_r);
        cls_b_s   = fp16_class(op_b_r);
        sign_s    = op_a_r.sign ^ op_b_r.sign;
        exp_sum_s = {2'b00, op_a_r.exp} + {2'b00, op_b_r.exp} - 7'(FP16_BIAS);
        special_s     = 1'b1;
        special_val_s = FP16_QNAN;
        if (cls_a_s == NAN || cls_b_s == NAN) begin
            special_val_s = FP16_QNAN;
        end else if ((cls_a_s == INF && cls_b_s == ZERO) || (cls_a_s == ZERO && cls_b_s == INF)) begin
            special_val_s = FP16_QNAN;
        end else if (cls_a_s == INF || cls_b_s == INF) begin
            special_val_s = {sign_s, 5'h1F, 10'h000};
        end else if (cls_a_s == ZERO || cls_b_s == ZERO) begin
            special_val_s = {sign_s, 15'h0000};
        end else begin
            special_s     = 1'b0;
        end
    end

    // S1 register: sign, exponent sum, significands with hidden bit, specials.
    always_ff @(posedge clk) begin
        if (RST) begin
            s1_valid_r       <= 1'b0;
            s1_sign_r        <= 1'b0;
            s1_exp_r         <= 7'sd0;
            s1_sig_a_r       <= 11'd0;
            s1_sig_b_r       <= 11'd0;
            s1_special_r     <= 1'b0;
            s1_special_val_r <= 16'h0000;
        end else if (!bus.stall) begin
            s1_valid_r       <= op_valid_r;
            s1_sign_r        <= sign_s;
            s1_exp_r         <= exp_sum_s;
            s1_sig_a_r       <= {1'b1, op_a_r.mant};
            s1_sig_b_r       <= {1'b1, op_b_r.mant};
            s1_special_r     <= special_s;
            s1_special_val_r <= special_val_s;
        end
    end

    // S2 register: significand product, carrying exponent and special result.
    always_ff @(posedge clk) begin
        if (RST) begin
            s2_valid_r       <= 1'b0;
            s2_sign_r        <= 1'b0;
            s2_exp_r         <= 7'sd0;
            s2_prod_r        <= 22'd0;
            s2_special_r     <= 1'b0;
            s2_special_val_r <= 16'h0000;
        end else if (!bus.stall) begin
            s2_valid_r       <= s1_valid_r;
            s2_sign_r        <= s1_sign_r;
            s2_exp_r         <= s1_exp_r;
            s2_prod_r        <= s1_sig_a_r * s1_sig_b_r;
            s2_special_r     <= s1_special_r;
            s2_special_val_r <= s1_special_val_r;
        end
    end

    fp16_round_pack u_round_pack (
        .sign       (s2_sign_r),
        .biased_exp (s2_exp_r),
        .prod       (s2_prod_r),
        .result     (packed_s)
    );

    // S3 output register; fp_out holds across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (RST) begin
            valid_out_r <= 1'b0;
            fp_out_r    <= 16'h0000;
        end else if (!bus.stall) begin
            valid_out_r <= s2_valid_r;
            if (s2_valid_r) begin
                fp_out_r <= s2_special_r ? s2_special_val_r : packed_s;
            end
        end
    end

    assign bus.fp_out    = fp_out_r;
    assign bus.valid_out = valid_out_r;

endmodule

// File: tb/tb_mul_fp16_pipe.sv
// Randomized and directed checks of mul_fp16_pipe against an arithmetic
// reference model delayed by the pipeline latency.
module tb_mul_fp16_pipe;

    logic clk = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   chk_en   = 1'b0;

    mul_fp16_pipe_if bus ();

    mul_fp16_pipe #(.LAT(3)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: exact integer significand product, generic RNE, DAZ/FTZ.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, p, k, sh, q, rem, half, e;
        logic s;
        bit na, nb, ia, ib, za, zb;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        na = (ea == 31) && (ma != 0); nb = (eb == 31) && (mb != 0);
        ia = (ea == 31) && (ma == 0); ib = (eb == 31) && (mb == 0);
        za = (ea == 0);               zb = (eb == 0);
        if (na || nb) return 16'h7D00;
        if ((ia && zb) || (ib && za)) return 16'h7D00;
        if (ia || ib) return {s, 15'h7C00};
        if (za || zb) return {s, 15'h0000};
        p = (1024 + ma) * (1024 + mb);
        k = 0;
        for (int i = 0; i < 31; i++) if (((p >> i) & 1) == 1) k = i;
        sh   = k - 10;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 2048) begin q = 1024; k = k + 1; end
        e = ea + eb - 15 + (k - 20);
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0)  return {s, 15'h0000};
        q = q - 1024;
        return {s, e[4:0], q[9:0]};
    endfunction

    // Latency model: three-deep delay line of reference results plus output hold.
    logic        mv [0:2];
    logic [15:0] md [0:2];
    logic        exp_valid;
    logic [15:0] exp_fp;
    always @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin mv[i] <= 1'b0; md[i] <= 16'h0000; end
            exp_valid <= 1'b0;
            exp_fp    <= 16'h0000;
        end else if (!bus.stall) begin
            exp_valid <= mv[2];
            if (mv[2]) exp_fp <= md[2];
            mv[2] <= mv[1]; md[2] <= md[1];
            mv[1] <= mv[0]; md[1] <= md[0];
            mv[0] <= bus.start;
            md[0] <= ref_mul(bus.fp1_in, bus.fp2_in);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Advance one cycle and compare the DUT against the model on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            chk("valid_out", {15'd0, bus.valid_out}, {15'd0, exp_valid});
            chk("fp_out", bus.fp_out, exp_fp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b);
        bus.start  = 1'b1;
        bus.fp1_in = a;
        bus.fp2_in = b;
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0: v[14:0] = 15'h0000;
            1: v[14:0] = 15'h7C00;
            2: begin v[14:10] = 5'h1F; v[9:0] = 10'($urandom_range(1, 1023)); end
            3: v[14:10] = 5'h00;
            4: v[14:10] = 5'($urandom_range(24, 30));
            5: v[14:10] = 5'($urandom_range(1, 8));
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    localparam logic [15:0] DA [12] = '{16'h3C00, 16'h3E00, 16'hC000, 16'h7E00, 16'h7C00, 16'hFC00,
                                        16'h8000, 16'h7BFF, 16'h0400, 16'h0001, 16'h3C01, 16'h3C01};
    localparam logic [15:0] DB [12] = '{16'h3C00, 16'h4000, 16'h4000, 16'h3C00, 16'h0000, 16'h4000,
                                        16'h3C00, 16'h7BFF, 16'h0400, 16'h3C00, 16'h3E00, 16'h3C01};
    localparam logic [15:0] DE [12] = '{16'h3C00, 16'h4200, 16'hC400, 16'h7D00, 16'h7D00, 16'hFC00,
                                        16'h8000, 16'h7C00, 16'h0000, 16'h0000, 16'h3E02, 16'h3C02};

    logic [15:0] sa [5];
    logic [15:0] sb [5];
    logic [15:0] got_q [$];
    logic [15:0] got;

    initial begin
        RST = 1'b1;
        bus.start = 1'b0; bus.stall = 1'b0; bus.fp1_in = 16'h0000; bus.fp2_in = 16'h0000;
        tick();
        bus.stall = 1'b1;
        tick();
        chk("reset_valid", {15'd0, bus.valid_out}, 16'h0000);
        chk("reset_fp", bus.fp_out, 16'h0000);
        bus.stall = 1'b0;
        chk_en = 1'b1;
        RST = 1'b0;

        // Directed vectors: pin the model, then check DUT latency and value.
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("model_%0d", i), ref_mul(DA[i], DB[i]), DE[i]);
            drive(DA[i], DB[i]);
            tick();
            bus.start = 1'b0;
            tick();
            tick();
            chk($sformatf("early_valid_%0d", i), {15'd0, bus.valid_out}, 16'h0000);
            tick();
            chk($sformatf("dir_valid_%0d", i), {15'd0, bus.valid_out}, 16'h0001);
            chk($sformatf("dir_fp_%0d", i), bus.fp_out, DE[i]);
        end

        // Back-to-back stream with a two-cycle stall in the middle.
        for (int i = 0; i < 5; i++) begin
            sa[i] = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
            sb[i] = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
        end
        got_q.delete();
        for (int c = 0; c < 12; c++) begin
            bus.stall = (c == 3 || c == 4);
            if (c < 3) drive(sa[c], sb[c]);
            else if (c == 5 || c == 6) drive(sa[c-2], sb[c-2]);
            else bus.start = 1'b0;
            tick();
            if (bus.valid_out && !bus.stall) got_q.push_back(bus.fp_out);
        end
        bus.stall = 1'b0;
        chk("stream_count", 16'(got_q.size()), 16'd5);
        for (int i = 0; i < 5; i++) begin
            got = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            chk($sformatf("stream_%0d", i), got, ref_mul(sa[i], sb[i]));
        end

        // Reset with three operations in flight, then an immediate new op.
        drive(16'h3C00, 16'h4400); tick();
        drive(16'h4000, 16'h4000); tick();
        drive(16'hBC00, 16'h4200); tick();
        bus.start = 1'b0;
        RST = 1'b1;
        tick();
        chk("rst_mid_valid", {15'd0, bus.valid_out}, 16'h0000);
        chk("rst_mid_fp", bus.fp_out, 16'h0000);
        RST = 1'b0;
        drive(16'h4000, 16'h4200);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("no_stale", {15'd0, bus.valid_out}, 16'h0000);
        end
        tick();
        chk("post_rst_valid", {15'd0, bus.valid_out}, 16'h0001);
        chk("post_rst_fp", bus.fp_out, 16'h4600);

        // Randomized traffic with bubbles and stalls.
        for (int c = 0; c < 400; c++) begin
            bus.stall = ($urandom_range(0, 6) == 0);
            bus.start = ($urandom_range(0, 3) != 0);
            bus.fp1_in = rand_op();
            bus.fp2_in = rand_op();
            tick();
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mul_fp16_pipe.md
# mul_fp16_pipe

Three-stage pipelined IEEE-754 binary16 multiplier for the systolic-array processing element. It sits directly upstream of `add_fp16`: it forms the weight×activation product, and the adder accumulates that product into the partial sum. Special-value handling matches the adder so the MAC datapath behaves consistently end to end:

- DAZ on inputs, FTZ on outputs.
- Canonical NaN.
- Round-to-nearest-even.

## Interface
- `LAT`, 3, pipeline depth in cycles; fixed at 3, exposed for the PE delay-matching logic.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `start`  in  1  input-valid; `fp1_in`/`fp2_in` are sampled when `start`=1 and `stall`=0.
- `stall`  in  1  freezes every pipeline register, including the valid bits and the outputs.
- `fp1_in`  in  16  operand A (activation), binary16.
- `fp2_in`  in  16  operand B (weight), binary16.
- `fp_out`  out  16  product, binary16.
- `valid_out`  out  1  `fp_out` holds a new product for this cycle.

## Operation
- Operand classes:
  - zero: exp=0, covering both zeros and subnormals (DAZ);
  - inf: exp=31, mant=0;
  - nan: exp=31, mant≠0;
  - normal: everything else.
- Special-result precedence, highest first:
  - any NaN operand → 0x7D00;
  - inf×zero → 0x7D00;
  - inf×(inf|normal) → inf with sign s1^s2;
  - zero×(zero|normal) → zero with sign s1^s2.
- Normal path:
  - sign = s1^s2.
  - Biased exponent e = e1+e2−15, held as a 7-bit signed value (range −13..45).
  - Product p[21:0] = {1,m1}×{1,m2}.
  - If p[21]=1: mant=p[20:11], guard=p[10], sticky=|p[9:0], and e+1.
  - Otherwise: mant=p[19:10], guard=p[9], sticky=|p[8:0].
- Rounding is RNE: increment when guard & (sticky | mant[0]). A carry out of mant sets mant=0 and e+1.
- Range checks, applied after rounding:
  - e ≥ 31 → inf with sign;
  - e ≤ 0 → signed zero (FTZ, no subnormal outputs).
- NaN output carries sign 0.
- Stage split:
  - S1: unpack, classify, sign, exponent sum, special-result selection.
  - S2: 11×11 mantissa multiply; the exponent and special flags are carried alongside.
  - S3: normalize, round, range check, pack into `fp_out`.
- Each stage has a valid bit. Stage registers load only when `stall`=0. A bubble (`start`=0) propagates as valid=0.

## Timing
- Latency is exactly 3 unstalled cycles: operands accepted at edge N appear on `fp_out` with `valid_out`=1 after edge N+3 (i.e. visible in cycle N+3).
- Throughput is one product per cycle; there is no backpressure apart from `stall`.
- `stall`=1: all registers hold. `fp_out` and `valid_out` keep their values, so a valid result is re-presented for as long as `stall` is high. Inputs presented during a stall are ignored.
- `fp_out` holds its last value when `valid_out`=0; it is not cleared by bubbles.
- Reset, on any edge with `RST`=1:
  - all valid bits cleared, `valid_out`=0, `fp_out`=0x0000;
  - in-flight operations are discarded;
  - `RST` overrides `stall`.
- The first accept after reset can occur on the first edge with `RST`=0.
- `start` together with `stall` → the input is dropped. The upstream PE guarantees it does not do this.

## Structure
- `fp16_pkg` (shared with `add_fp16`):
  - typedef `fp16_t` as a packed struct {sign, exp[4:0], mant[9:0]};
  - constants `FP16_BIAS`=15, `FP16_QNAN`=16'h7D00, `FP16_PINF`=16'h7C00, `FP16_NINF`=16'hFC00;
  - function `fp16_class` returning an enum {ZERO, NORM, INF, NAN}.
- One sub-module: `fp16_round_pack`, the S3 combinational normalize/RNE/range/pack logic. It is reusable by `add_fp16`.
- S2 multiply is a plain `*` on 11-bit operands; synthesis infers the DSP.

## Test plan
- Directed products, each followed 3 cycles later by `valid_out`=1:
  - 0x3C00×0x3C00 → 0x3C00;
  - 0x3E00×0x4000 (1.5×2) → 0x4200;
  - 0xC000×0x4000 → 0xC400.
- Specials:
  - 0x7E00×0x3C00 → 0x7D00;
  - 0x7C00×0x0000 → 0x7D00;
  - 0xFC00×0x4000 → 0xFC00;
  - 0x8000×0x3C00 → 0x8000.
- Range handling:
  - 0x7BFF×0x7BFF → 0x7C00;
  - 0x0400×0x0400 → 0x0000 (FTZ);
  - 0x0001×0x3C00 → 0x0000 (DAZ).
- Rounding:
  - 0x3C01×0x3E00 (tie, odd lsb) → 0x3E02;
  - 0x3C01×0x3C01 → 0x3C02.
- Pipeline/stall stream: feed 5 back-to-back operand pairs with `stall`=1 for 2 cycles mid-stream.
  - Expect 5 results in order, no duplicates or losses.
  - `fp_out` is held constant during the stall.
- Reset mid-flight: assert `RST` for 1 cycle while 3 ops are in flight.
  - Next cycle: `valid_out`=0 and `fp_out`=0x0000.
  - No stale results emerge afterward.
  - A new op issued immediately after reset returns correctly at latency 3.
